// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, 32 iterations each.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise ops 100-111 complete as illegal.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        illegal
);

`ifdef MULDIV_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [4:0]  cnt_q;
  logic        neg_q;
  logic        illegal_q;
  logic [31:0] result_q;

  logic [63:0] acc_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;

  logic        accept;
  logic        a_sgn, b_sgn, neg_d;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_nxt, prod_fix;
  logic [31:0] mul_res;

`ifdef MULDIV_DIV_EN
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] diff, rem_nxt, quo_nxt, div_res;
  logic        div_zero, div_ovf, is_special;
  logic [31:0] spec_res;
`endif

`ifdef MULDIV_DIV_EN
  assign busy = (state_q == MUL) || (state_q == DIV);
`else
  assign busy = (state_q == MUL);
`endif
  assign done    = (state_q == DONE);
  assign illegal = done && illegal_q;
  assign result  = result_q;
  assign accept  = start && !busy;

  // Operand signedness depends on the op being accepted, not the captured one.
  always_comb begin
    a_sgn = a[31] && (op[2] ? !op[0] : (op[1:0] != 2'b11));
    b_sgn = b[31] && (op[2] ? !op[0] : !op[1]);
    a_mag = a_sgn ? (~a + 32'd1) : a;
    b_mag = b_sgn ? (~b + 32'd1) : b;
`ifdef MULDIV_DIV_EN
    neg_d = (op[2] && op[1]) ? a_sgn : (a_sgn ^ b_sgn);
`else
    neg_d = a_sgn ^ b_sgn;
`endif
  end

  always_comb begin
    prod_nxt = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
    prod_fix = neg_q ? (~prod_nxt + 64'd1) : prod_nxt;
    mul_res  = (op_q == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
  end

`ifdef MULDIV_DIV_EN
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    ge      = (shifted >= {1'b0, dvs_q});
    // Remainder stays below the divisor, so a 32-bit subtract is exact when ge is set.
    diff    = shifted[31:0] - dvs_q;
    rem_nxt = ge ? diff : shifted[31:0];
    quo_nxt = {quo_q[30:0], ge};
    if (op_q[1])
      div_res = neg_q ? (~rem_nxt + 32'd1) : rem_nxt;
    else
      div_res = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
  end

  always_comb begin
    div_zero   = (b == '0);
    div_ovf    = !op[0] && (a == 32'h8000_0000) && (b == '1);
    is_special = div_zero || div_ovf;
    if (div_zero)
      spec_res = op[1] ? a : '1;
    else
      spec_res = op[1] ? '0 : 32'h8000_0000;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      MUL:  if (cnt_q == 5'd31) state_d = DONE;
`ifdef MULDIV_DIV_EN
      DIV:  if (cnt_q == 5'd31) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      if (!op[2])
        state_d = MUL;
      else begin
`ifdef MULDIV_DIV_EN
        state_d = is_special ? DONE : DIV;
`else
        state_d = DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      illegal_q <= 1'b0;
      result_q  <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
`ifdef MULDIV_DIV_EN
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
`endif
    end else begin
      case (state_q)
        MUL: begin
          acc_q    <= prod_nxt;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) result_q <= mul_res;
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) result_q <= div_res;
        end
`endif
        default: begin
          if (accept) begin
            op_q      <= op[1:0];
            cnt_q     <= '0;
            neg_q     <= neg_d;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= {32'd0, a_mag};
            mplier_q  <= b_mag;
`ifdef MULDIV_DIV_EN
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            if (op[2] && is_special) result_q <= spec_res;
`else
            if (op[2]) begin
              result_q  <= '0;
              illegal_q <= 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Port clk, input, 1: single clock; all state changes on posedge clk.
REQ-002 Port rst, input, 1: reset, synchronous, active-high.
REQ-003 Port start, input, 1: request a new operation; accepted only when busy=0.
REQ-004 Port op, input, 3: RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-005 Port a, input, 32: rs1 operand, driven from register file rd1.
REQ-006 Port b, input, 32: rs2 operand, driven from register file rd2.
REQ-007 Port busy, output, 1: operation in progress; start ignored while high.
REQ-008 Port done, output, 1: one-cycle pulse; result valid in that cycle.
REQ-009 Port result, output, 32: write-back data for register file wd3; held until next accepted start.
REQ-010 Port illegal, output, 1: qualifies done; operation not supported in this build.

Function
REQ-011 Accept: cycle k with start=1 and busy=0 shall capture op, a and b; later changes to a/b/op shall have no effect.
REQ-012 FSM states IDLE, MUL, DIV, DONE; IDLE->MUL on accepted op[2]=0, IDLE->DIV on accepted op[2]=1, MUL/DIV->DONE after 32 iterations, DONE->IDLE unless start=1 (DONE->MUL/DIV on accepted start).
REQ-013 busy=1 in MUL and DIV only; busy=0 in IDLE and DONE; done=1 only in DONE.
REQ-014 Multiply: iterative shift-add on operand magnitudes, one bit per cycle, 64-bit product; sign correction applied on entry to DONE.
REQ-015 Signedness: MUL/MULH treat both operands as signed; MULHSU treats a signed, b unsigned; MULHU treats both unsigned.
REQ-016 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
REQ-017 Divide: iterative restoring division on magnitudes, one quotient bit per cycle; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) (DIV/REM only).
REQ-018 Normal latency: done=1 in cycle k+33 for every multiply and non-special divide.
REQ-019 Divide by zero (b=0): DIV/DIVU return 32'hFFFF_FFFF; REM/REMU return a; bypass iterations, done=1 in cycle k+1.
REQ-020 Signed overflow (a=32'h8000_0000, b=32'hFFFF_FFFF): DIV returns 32'h8000_0000, REM returns 0; done=1 in cycle k+1.
REQ-021 start asserted while busy=1 shall be ignored and shall not alter the running operation.
REQ-022 start in the DONE cycle shall be accepted, giving back-to-back operations with no idle cycle.
REQ-023 illegal shall be 0 whenever done=0.

Reset
REQ-024 rst=1 at a posedge shall force IDLE, busy=0, done=0, illegal=0, result=0 and clear the iteration counter and internal operand registers.
REQ-025 rst during MUL, DIV or DONE shall abort the operation; no done pulse shall follow.
REQ-026 start coincident with rst shall be ignored.

Configuration
REQ-027 Macro MULDIV_DIV_EN defined: divide datapath and DIV state present; ops 100-111 behave per REQ-017..REQ-020.
REQ-028 Macro MULDIV_DIV_EN undefined: no divide datapath or DIV state; ops 100-111 give done=1, illegal=1, result=0 in cycle k+1; multiply unchanged.

Verification
REQ-029 MUL a=7, b=-3 (32'hFFFF_FFFD), start cycle k -> busy cycles k+1..k+32, done in k+33, result=32'hFFFF_FFEB, illegal=0.
REQ-030 MULHU a=b=32'hFFFF_FFFF -> result=32'hFFFF_FFFE; MULH same operands -> result=0; MULHSU a=-1, b=2 -> result=32'hFFFF_FFFF.
REQ-031 DIV a=-20, b=3 -> result=-6 (32'hFFFF_FFFA) in k+33; REM same -> result=-2 (32'hFFFF_FFFE).
REQ-032 DIVU a=5, b=0 -> done in k+1, result=32'hFFFF_FFFF; REM a=32'h8000_0000, b=-1 -> done in k+1, result=0.
REQ-033 MUL started, start re-pulsed at k+10 with new operands, rst=1 at k+20 -> first result unaffected before reset, busy=0 and no done after k+20, result=0.
REQ-034 Build without MULDIV_DIV_EN, DIVU a=9, b=3 -> done=1, illegal=1, result=0 in k+1; MUL a=3, b=4 -> result=12 in k+33.
